ce_output_buf_axil_regs: RTL and testbench

AXI4-Lite slave (responder) register file for the CE output buffer IP. It terminates the control interface driven by the system AXI4-Lite master and exposes four 32-bit control/status registers to the buffer datapath. Write address and write data are accepted independently. Every write and read gets a response: OKAY, or SLVERR when the address is out of range.

---
 rtl/ce_output_buf_pkg.sv | 50 +++++
 rtl/ce_axil_addr_decode.sv | 49 ++++
 rtl/ce_output_buf_axil_regs.sv | 205 ++++++++++++++++++++
 tb/tb_ce_output_buf_axil_regs.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_output_buf_pkg.sv
// ============================================================================
// Module      : ce_output_buf_pkg
// Description : Shared constants and types for the CE output buffer AXI4-Lite
//               register file: register offsets, response codes, FSM states
//               and the byte-strobe merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ce_output_buf_pkg;

  localparam int CE_NUM_REGS = 4;
  localparam int CE_IDX_W    = 2;
  localparam int CE_DATA_W   = 32;

  localparam int unsigned CE_REG0_OFFS = 32'h0;
  localparam int unsigned CE_REG1_OFFS = 32'h4;
  localparam int unsigned CE_REG2_OFFS = 32'h8;
  localparam int unsigned CE_REG3_OFFS = 32'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [CE_DATA_W-1:0] ce_strb_merge(
    input logic [CE_DATA_W-1:0]   old_val,
    input logic [CE_DATA_W-1:0]   new_val,
    input logic [CE_DATA_W/8-1:0] strb
  );
    logic [CE_DATA_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < CE_DATA_W/8; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_axil_addr_decode.sv
// ============================================================================
// Module      : ce_axil_addr_decode
// Description : Combinational byte address to {register index, in_range}
//               decoder shared by the read and write channels. Address bits
//               [1:0] are ignored; anything outside the four word offsets is
//               out of range.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_axil_addr_decode
  import ce_output_buf_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [CE_IDX_W-1:0] idx,
  output logic                in_range
);

  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_lsbs;

  // Byte lane bits never take part in the decode.
  assign word_addr        = {addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsbs = ^addr[1:0];

  // Match the word address against the register offset table.
  always_comb begin
    idx      = '0;
    in_range = 1'b0;
    if (word_addr == ADDR_W'(CE_REG0_OFFS)) begin
      idx      = 2'd0;
      in_range = 1'b1;
    end else if (word_addr == ADDR_W'(CE_REG1_OFFS)) begin
      idx      = 2'd1;
      in_range = 1'b1;
    end else if (word_addr == ADDR_W'(CE_REG2_OFFS)) begin
      idx      = 2'd2;
      in_range = 1'b1;
    end else if (word_addr == ADDR_W'(CE_REG3_OFFS)) begin
      idx      = 2'd3;
      in_range = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ce_output_buf_axil_regs.sv
// ============================================================================
// Module      : ce_output_buf_axil_regs
// Description : AXI4-Lite responder exposing four 32-bit control/status
//               registers to the CE output buffer datapath. Write address and
//               data are collected independently; reads and writes run on
//               fully independent state machines.
//               Build option: CE_OUTPUT_BUF_WSTRB_EN enables per-byte WSTRB
//               masking (otherwise every in-range write replaces all bytes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_output_buf_axil_regs
  import ce_output_buf_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] REG_RESET_VAL      = 32'h0
) (
  input  logic                                      ACLK,
  input  logic                                      ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY,
  output logic [CE_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REGS_O,
  output logic [CE_NUM_REGS-1:0]                    WR_PULSE_O
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                out_of_reset;
  logic                aw_held, w_held;
  logic [AW-1:0]       aw_addr_q;
  logic [DW-1:0]       w_data_q;
  logic [DW/8-1:0]     w_strb_q;
  logic [DW-1:0]       regs [CE_NUM_REGS];

  logic [CE_IDX_W-1:0] wr_idx, rd_idx;
  logic                wr_in_range, rd_in_range;
  logic                aw_hs, w_hs, ar_hs, commit;
  logic                unused_ok;

  // Protection bits carry no meaning here; strobes are unused when masking is off.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_strb_q};

  ce_axil_addr_decode #(.ADDR_W(AW)) u_wr_decode (
    .addr     (aw_addr_q),
    .idx      (wr_idx),
    .in_range (wr_in_range)
  );

  ce_axil_addr_decode #(.ADDR_W(AW)) u_rd_decode (
    .addr     (S_AXI_ARADDR),
    .idx      (rd_idx),
    .in_range (rd_in_range)
  );

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (wr_state == W_COLLECT) && aw_held && w_held;

  // Readies stay low until the first edge after reset releases.
  always_ff @(posedge ACLK) begin
    if (ARESET) out_of_reset <= 1'b0;
    else        out_of_reset <= 1'b1;
  end

  // ---------------------------------------------------------------- write FSM
  // Write state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state <= W_COLLECT;
    else        wr_state <= wr_state_nxt;
  end

  // Write next-state: commit once both halves are held, leave on B handshake.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_COLLECT: if (commit)       wr_state_nxt = W_RESP;
      W_RESP:    if (S_AXI_BREADY) wr_state_nxt = W_COLLECT;
      default:                     wr_state_nxt = W_COLLECT;
    endcase
  end

  // Write channel handshake outputs.
  always_comb begin
    S_AXI_AWREADY = out_of_reset && (wr_state == W_COLLECT) && !aw_held;
    S_AXI_WREADY  = out_of_reset && (wr_state == W_COLLECT) && !w_held;
    S_AXI_BVALID  = (wr_state == W_RESP);
  end

  // Latch address and data halves independently; a commit consumes both.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Response code and one-cycle write pulse, both set by the commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_BRESP <= RESP_OKAY;
      WR_PULSE_O  <= '0;
    end else begin
      for (int i = 0; i < CE_NUM_REGS; i++) begin
        WR_PULSE_O[i] <= commit && wr_in_range && (wr_idx == CE_IDX_W'(i));
      end
      if (commit) S_AXI_BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Register array update on an in-range commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < CE_NUM_REGS; i++) regs[i] <= REG_RESET_VAL;
    end else if (commit && wr_in_range) begin
`ifdef CE_OUTPUT_BUF_WSTRB_EN
      regs[wr_idx] <= ce_strb_merge(regs[wr_idx], w_data_q, w_strb_q);
`else
      regs[wr_idx] <= w_data_q;
`endif
    end
  end

  // ----------------------------------------------------------------- read FSM
  // Read state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read next-state: accept one address, hold data until RREADY.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)        rd_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
      default:                   rd_state_nxt = R_IDLE;
    endcase
  end

  // Read channel handshake outputs.
  always_comb begin
    S_AXI_ARREADY = out_of_reset && (rd_state == R_IDLE);
    S_AXI_RVALID  = (rd_state == R_DATA);
  end

  // Capture read data at the address handshake; a same-cycle commit is not yet visible.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_in_range ? regs[rd_idx] : '0;
      S_AXI_RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  generate
    for (genvar gi = 0; gi < CE_NUM_REGS; gi++) begin : g_regs_out
      assign REGS_O[gi*DW +: DW] = regs[gi];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ce_output_buf_axil_regs.sv
// ============================================================================
// Module      : tb_ce_output_buf_axil_regs
// Description : Self-checking bench for ce_output_buf_axil_regs. Expected
//               B and R responses are queued by the stimulus tasks and popped
//               by an independent monitor on each completed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ce_output_buf_axil_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] regs_o;
  logic [3:0]   wr_pulse;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [3:0]  pulse_acc = '0;
  logic [31:0] exp_r0;

  ce_output_buf_axil_regs dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .REGS_O        (regs_o),
    .WR_PULSE_O    (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completed B and R handshake against the queues.
  always @(negedge clk) begin
    logic [1:0]  eb;
    logic [33:0] er;
    pulse_acc = pulse_acc | wr_pulse;
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; failures++;
        $display("FAIL bresp_unexpected actual=%0h required=none", bresp);
      end else begin
        eb = bq.pop_front();
        chk("bresp", {126'd0, bresp}, {126'd0, eb});
      end
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_unexpected actual=%0h required=none", {rresp, rdata});
      end else begin
        er = rq.pop_front();
        chk("rresp_rdata", {94'd0, rresp, rdata}, {94'd0, er});
      end
    end
  end

  // Full write; caller is at the drive phase (#1 after a rising edge).
  task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    int n;
    logic aw_hs, w_hs;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      checks++; failures++;
      $display("FAIL write_accept_timeout actual=busy required=accepted");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL bvalid_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Full read; caller is at the drive phase.
  task automatic do_read(input logic [5:0] a, input logic [1:0] er, input logic [31:0] ed);
    int n;
    logic hs;
    rq.push_back({er, ed});
    araddr = a; arvalid = 1'b1;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL ar_accept_timeout actual=0 required=1");
    end
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef CE_OUTPUT_BUF_WSTRB_EN
    exp_r0 = 32'hFF00FF00;
`else
    exp_r0 = 32'h00000000;
`endif
    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_readies", {125'd0, awready, wready, arready}, 128'd0);
    chk("reset_valids", {126'd0, bvalid, rvalid}, 128'd0);
    chk("reset_regs", regs_o, 128'd0);
    chk("reset_resp_data_pulse", {90'd0, bresp, rresp, rdata, wr_pulse}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arready_after_reset", {127'd0, arready}, 128'd1);
    @(posedge clk); #1;

    // ---------------- sequential write / read-back
    do_write(6'h0, 32'h0101FFFF, 4'hF, 2'b00);
    do_write(6'h4, 32'habcd0001, 4'hF, 2'b00);
    do_write(6'h8, 32'hdead0011, 4'hF, 2'b00);
    do_write(6'hC, 32'hbeef0011, 4'hF, 2'b00);
    do_read(6'h0, 2'b00, 32'h0101FFFF);
    do_read(6'h4, 2'b00, 32'habcd0001);
    do_read(6'h8, 2'b00, 32'hdead0011);
    do_read(6'hC, 2'b00, 32'hbeef0011);
    chk("regs_after_seq", regs_o, {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF});

    // ---------------- skewed: W leads AW by 3 cycles
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("skew_wready_before", {127'd0, wready}, 128'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("skew_wready_after_hs", {126'd0, wready, bvalid}, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 6'h4; awvalid = 1'b1;
    @(negedge clk);
    chk("skew_awready", {127'd0, awready}, 128'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("skew_bvalid_not_yet", {127'd0, bvalid}, 128'd0);
    @(negedge clk);
    chk("skew_bvalid_pulse", {123'd0, bvalid, wr_pulse}, {123'd0, 1'b1, 4'b0010});
    chk("skew_reg1", {96'd0, regs_o[63:32]}, {96'd0, 32'h12345678});
    @(negedge clk);
    chk("skew_pulse_one_cycle", {123'd0, bvalid, wr_pulse}, {123'd0, 1'b1, 4'b0000});
    @(posedge clk); #1;
    bq.push_back(2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // ---------------- strobe
    do_write(6'h0, 32'hFFFFFFFF, 4'hF, 2'b00);
    do_write(6'h0, 32'h00000000, 4'b0101, 2'b00);
    do_read(6'h0, 2'b00, exp_r0);

    // ---------------- out of range
    pulse_acc = '0;
    do_write(6'h10, 32'hA5A5A5A5, 4'hF, 2'b10);
    chk("oor_no_pulse", {124'd0, pulse_acc}, 128'd0);
    do_read(6'h10, 2'b10, 32'h0);
    chk("oor_regs_unchanged", regs_o, {32'hbeef0011, 32'hdead0011, 32'h12345678, exp_r0});

    // ---------------- backpressure on B and R
    awaddr = 6'hC; wdata = 32'h0F0F0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h4; arvalid = 1'b1;
    @(negedge clk);
    chk("bp_all_ready", {125'd0, awready, wready, arready}, {125'd0, 3'b111});
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", {89'd0, bvalid, bresp, rvalid, rresp, rdata, awready, wready},
          {89'd0, 1'b1, 2'b00, 1'b1, 2'b00, 32'h12345678, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h12345678});
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_b", {126'd0, awready, wready}, {126'd0, 2'b11});
    chk("bp_reg3", {96'd0, regs_o[127:96]}, {96'd0, 32'h0F0F0F0F});
    @(posedge clk); #1;

    // ---------------- reset between AW and W
    awaddr = 6'h8; awvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", {127'd0, awready}, 128'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_bvalid", {123'd0, bvalid, wr_pulse}, 128'd0);
      @(posedge clk); #1;
    end
    do_read(6'h0, 2'b00, 32'h0);
    do_read(6'h4, 2'b00, 32'h0);
    do_read(6'h8, 2'b00, 32'h0);
    do_read(6'hC, 2'b00, 32'h0);
    chk("rst_regs_cleared", regs_o, 128'd0);
    do_write(6'h8, 32'hCAFEF00D, 4'hF, 2'b00);
    do_read(6'h8, 2'b00, 32'hCAFEF00D);
    chk("rst_regs_final", regs_o, {32'h0, 32'hCAFEF00D, 32'h0, 32'h0});

    repeat (2) @(posedge clk);
    chk("queues_drained", {96'd0, 32'(bq.size() + rq.size())}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
